// File: rtl/mul_rr_scheduler_pkg.sv
// Shared definitions for the round-robin multiplier scheduler.
//   state_e     : controller FSM states (encodings fixed so traces stay readable)
//   StateW      : FSM state register width
//   DefaultW    : default operand/product width (matches datapath data_in / P)
//   DefaultNreq : default number of requesters
package mul_rr_scheduler_pkg;

  localparam int unsigned StateW      = 3;
  localparam int unsigned DefaultW    = 16;
  localparam int unsigned DefaultNreq = 4;

  typedef enum logic [StateW-1:0] {
    StIdle  = 3'd0,
    StLoadA = 3'd1,
    StLoadB = 3'd2,
    StAdd   = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/mul_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter.
//   req_i   : per-requester request levels
//   ptr_i   : highest-priority index for this pick
//   gnt_o   : one-hot grant (all zero when nothing requests)
//   idx_o   : index of the granted requester
//   valid_o : some requester was granted
module mul_rr_scheduler_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            valid_o
);

  always_comb begin
    int unsigned cand;
    logic [IDW-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    // Scan ptr, ptr+1, ... wrapping at NREQ; first hit wins.
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand     = (32'(ptr_i) + k) % NREQ;
      cand_idx = IDW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mul_rr_scheduler.sv
// Shares one repeated-addition multiplier datapath among NREQ requesters.
// A requester is picked round-robin, its A and B are loaded onto the datapath, P is
// accumulated until B reaches zero, and the product is returned tagged with the owner id.
//   clk, rst            : clock, asynchronous active-high reset
//   req                 : level requests, held until the matching done pulse
//   a_in, b_in          : per-requester operands, slice i = [i*W +: W]
//   eqz, p_in           : datapath B==0 flag and running product
//   data_bus            : datapath data_in (zero outside the load states)
//   LdA/LdB/LdP/clrP/decB : datapath strobes
//   busy                : operation in progress
//   gnt                 : one-hot owner, LOAD_A through DONE
//   done, resp_valid    : one-cycle completion pulses
//   res, resp_id        : product and owner index
module mul_rr_scheduler
  import mul_rr_scheduler_pkg::*;
#(
  parameter int unsigned NREQ = DefaultNreq,
  parameter int unsigned W    = DefaultW,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  input  logic              eqz,
  input  logic [W-1:0]      p_in,
  output logic [W-1:0]      data_bus,
  output logic              LdA,
  output logic              LdB,
  output logic              LdP,
  output logic              clrP,
  output logic              decB,
  output logic              busy,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      res,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [W-1:0]    res_q, res_d;
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;
  logic            arb_valid;
  logic [W-1:0]    a_sel, b_sel;

  mul_rr_scheduler_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arbiter (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign a_sel = a_in[int'(owner_q)*W +: W];
  assign b_sel = b_in[int'(owner_q)*W +: W];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    gnt_d        = gnt_q;
    done_d       = '0;
    res_d        = res_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d = StLoadA;
          owner_d = arb_idx;
          gnt_d   = arb_gnt;
        end
      end
      StLoadA: state_d = StLoadB;
      StLoadB: state_d = StAdd;
      StAdd: begin
        // P is final once B hits zero; capture now so res/done line up with DONE.
        if (eqz) begin
          state_d      = StDone;
          res_d        = p_in;
          resp_id_d    = owner_q;
          resp_valid_d = 1'b1;
          done_d       = NREQ'(1) << owner_q;
        end
      end
      StDone: begin
        state_d = StIdle;
        gnt_d   = '0;
        // Move past the owner so it queues behind other pending requesters.
        if (owner_q == IDW'(NREQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = owner_q + IDW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      owner_q      <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      res_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      res_q        <= res_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
    end
  end

  // Strobes decode from the registered state; LdP/decB also follow eqz so the
  // datapath stops accumulating in the same cycle B reads zero.
  always_comb begin
    data_bus = '0;
    LdA      = 1'b0;
    LdB      = 1'b0;
    LdP      = 1'b0;
    clrP     = 1'b0;
    decB     = 1'b0;
    unique case (state_q)
      StLoadA: begin
        data_bus = a_sel;
        LdA      = 1'b1;
      end
      StLoadB: begin
        data_bus = b_sel;
        LdB      = 1'b1;
        clrP     = 1'b1;
      end
      StAdd: begin
        if (!eqz) begin
          LdP  = 1'b1;
          decB = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign gnt        = gnt_q;
  assign done       = done_q;
  assign res        = res_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Bench for mul_rr_scheduler paired with a repeated-addition datapath.
module tb_mul_rr_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in, b_in;
  logic              eqz;
  logic [W-1:0]      p_in;
  logic [W-1:0]      data_bus;
  logic              LdA, LdB, LdP, clrP, decB, busy;
  logic [NREQ-1:0]   gnt, done;
  logic [W-1:0]      res;
  logic              resp_valid;
  logic [IDW-1:0]    resp_id;

  mul_rr_scheduler #(
    .NREQ (NREQ),
    .W    (W),
    .IDW  (IDW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .eqz        (eqz),
    .p_in       (p_in),
    .data_bus   (data_bus),
    .LdA        (LdA),
    .LdB        (LdB),
    .LdP        (LdP),
    .clrP       (clrP),
    .decB       (decB),
    .busy       (busy),
    .gnt        (gnt),
    .done       (done),
    .res        (res),
    .resp_valid (resp_valid),
    .resp_id    (resp_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Repeated-addition datapath.
  logic [W-1:0] dp_a = '0, dp_b = '0, dp_p = '0;
  always @(posedge clk) begin
    if (LdA) dp_a <= data_bus;
    if (LdB) dp_b <= data_bus;
    else if (decB) dp_b <= dp_b - 16'd1;
    if (clrP) dp_p <= '0;
    else if (LdP) dp_p <= dp_p + dp_a;
  end
  assign eqz  = (dp_b == '0);
  assign p_in = dp_p;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   res;
  } exp_t;
  exp_t exp_q[$];

  int n_pass = 0;
  int n_total = 0;
  int resp_count = 0;
  int last_resp_cyc = 0;
  int cnt_lda = 0, cnt_ldb = 0, cnt_ldp = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every response and polices strobe rules.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (LdA) cnt_lda++;
        if (LdB && clrP) cnt_ldb++;
        if (LdP && decB) cnt_ldp++;
        if (LdA && (LdB || clrP || LdP || decB)) bad++;
        if (LdB != clrP) bad++;
        if (LdP != decB) bad++;
        if (LdB && LdP) bad++;
        if (!(LdA || LdB) && data_bus != '0) bad++;
        if (!resp_valid && done != '0) bad++;
        if ($countones(gnt) > 1) bad++;
        if (resp_valid) begin
          resp_count++;
          last_resp_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_resp: got id %0d res %0h expected no response",
                     resp_id, res);
          end else begin
            e = exp_q.pop_front();
            check("res", 32'(res), 32'(e.res));
            check("resp_id", 32'(resp_id), 32'(e.id));
            check("done_onehot", 32'(done), 32'(1) << e.id);
            check("gnt_at_done", 32'(gnt), 32'(1) << e.id);
          end
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic expect_resp(input int id, input logic [W-1:0] r);
    exp_t e;
    e.id  = IDW'(id);
    e.res = r;
    exp_q.push_back(e);
  endtask

  task automatic clear_counts();
    cnt_lda = 0;
    cnt_ldb = 0;
    cnt_ldp = 0;
  endtask

  // Wait for n done pulses, dropping req bits in drop_mask as they complete.
  task automatic run_until(input int n, input logic [NREQ-1:0] drop_mask, input int budget);
    int seen = 0;
    int k = 0;
    while (seen < n && k < budget) begin
      @(negedge clk);
      k++;
      if (done != '0) begin
        seen += $countones(done);
        req = req & ~(done & drop_mask);
      end
    end
    req = '0;
    if (seen < n) check("timeout_done", 32'(seen), 32'(n));
    #1;
  endtask

  task automatic single(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] r, input int lat);
    int t0;
    set_op(id, a, b);
    expect_resp(id, r);
    @(negedge clk);
    req = NREQ'(1) << id;
    t0 = cyc;
    run_until(1, '1, 60);
    check("latency", 32'(last_resp_cyc - t0), 32'(lat));
  endtask

  initial begin
    int t0;
    int k;
    int rc;
    rst  = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_res", 32'(res), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_id", 32'(resp_id), 0);
    check("rst_data_bus", 32'(data_bus), 0);
    check("rst_strobes", 32'({LdA, LdB, LdP, clrP, decB}), 0);
    rst = 1'b0;

    // 1: single user, 17*5.
    clear_counts();
    set_op(0, 16'd17, 16'd5);
    expect_resp(0, 16'd85);
    @(negedge clk);
    req = 4'b0001;
    t0  = cyc;
    @(negedge clk);
    check("t1_lda", 32'(LdA), 1);
    check("t1_bus_a", 32'(data_bus), 17);
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_busy", 32'(busy), 1);
    run_until(1, '1, 40);
    check("t1_latency", 32'(last_resp_cyc - t0), 9);
    check("t1_lda_count", 32'(cnt_lda), 1);
    check("t1_ldb_count", 32'(cnt_ldb), 1);
    check("t1_ldp_count", 32'(cnt_ldp), 5);

    // 2: round-robin from a fresh pointer, all requests held.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, W'(i + 2), 16'd3);
    expect_resp(0, 16'd6);
    expect_resp(1, 16'd9);
    expect_resp(2, 16'd12);
    expect_resp(3, 16'd15);
    expect_resp(0, 16'd6);
    @(negedge clk);
    req = 4'b1111;
    run_until(5, '0, 200);
    repeat (3) @(negedge clk);
    check("t2_idle_busy", 32'(busy), 0);
    check("t2_idle_gnt", 32'(gnt), 0);

    // 3: edge operands.
    single(1, 16'd9, 16'd0, 16'd0, 4);
    single(2, 16'd0, 16'd4, 16'd0, 8);
    single(3, 16'hFFFF, 16'd2, 16'hFFFE, 6);

    // 4: pointer wrap; after serving 2 the pointer is 3, so 0 beats 2.
    single(2, 16'd5, 16'd1, 16'd5, 5);
    set_op(0, 16'd2, 16'd2);
    set_op(2, 16'd3, 16'd3);
    expect_resp(0, 16'd4);
    expect_resp(2, 16'd9);
    @(negedge clk);
    req = 4'b0101;
    run_until(2, '1, 80);

    // 5: owner drops req mid-ADD.
    set_op(1, 16'd3, 16'd6);
    expect_resp(1, 16'd18);
    @(negedge clk);
    req = 4'b0010;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!LdP && k < 20);
    check("t5_in_add", 32'(LdP), 1);
    req = '0;
    run_until(1, '1, 40);
    repeat (4) @(negedge clk);
    check("t5_no_regrant_busy", 32'(busy), 0);
    check("t5_no_regrant_gnt", 32'(gnt), 0);

    // 6: reset during ADD discards the op.
    set_op(3, 16'd7, 16'd10);
    @(negedge clk);
    req = 4'b1000;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!LdP && k < 20);
    @(negedge clk);
    @(negedge clk);
    rc  = resp_count;
    rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_gnt", 32'(gnt), 0);
    check("t6_rst_strobes", 32'({LdA, LdB, LdP, clrP, decB}), 0);
    check("t6_rst_bus", 32'(data_bus), 0);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_no_done", 32'(resp_count), 32'(rc));
    set_op(1, 16'd2, 16'd3);
    expect_resp(1, 16'd6);
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    check("t6_gnt1", 32'(gnt), 32'h2);
    check("t6_bus_a", 32'(data_bus), 2);
    run_until(1, '1, 40);

    repeat (2) @(negedge clk);
    check("strobe_rules", 32'(bad), 0);
    check("queue_empty", 32'(exp_q.size()), 0);
    check("resp_total", 32'(resp_count), 14);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish within 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
